ines_load_ctrl: RTL and testbench

INES_LOAD_CTRL -- requirements
Module: ines_load_ctrl

---
 rtl/ines_load_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_ines_load_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ines_load_ctrl.sv
// iNES image loader: parses the 16-byte header, skips an optional trainer, then streams PRG and CHR into memory.
// Latency: a byte accepted in cycle N reaches the FIFO head in N+1; memory writes are issued directly from the head.
// Backpressure: in_ready falls while the 4-entry FIFO is full; a mem_ready stall holds mem_addr/mem_wdata stable.
// Build option: define LOADER_TIMEOUT_EN to abort a stalled load with err_code=3 after 2^20-1 idle busy cycles.

module ines_load_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic [2:0]   count
);
    logic [W-1:0] mem [4];
    logic [1:0]   wr_ptr;
    logic [1:0]   rd_ptr;

    // Pointers and occupancy; the owner only pushes when not full and only pops when not empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is write-only on push; contents are ignored while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module ines_load_ctrl #(
    parameter logic [21:0] PRG_BASE      = 22'h000000,
    parameter logic [21:0] CHR_BASE      = 22'h080000,
    parameter int          MAX_PRG_BANKS = 32,
    parameter int          MAX_CHR_BANKS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [7:0]  mapper,
    output logic [7:0]  prg_banks,
    output logic [7:0]  chr_banks,
    output logic        mirror
);
    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_TRAINER, S_PRG, S_CHR, S_DONE, S_ERROR
    } state_t;

    state_t      state, state_nxt;
    logic        rst_q;
    logic        rst_n;
    logic [7:0]  head_dat;
    logic [2:0]  count;
    logic        fifo_empty;
    logic        push, pop, fifo_clr;
    logic [3:0]  hdr_idx;
    logic        hdr_take;
    logic [21:0] offset;
    logic        off_inc, off_clr;
    logic        trainer_flag;
    logic        err_set;
    logic [1:0]  err_code_nxt;
    logic [7:0]  magic_byte;
    logic [21:0] prg_last, chr_last;
`ifdef LOADER_TIMEOUT_EN
    logic [19:0] idle_cnt;
`endif

    // Reset asserts asynchronously and releases on the first clock edge after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_q <= 1'b0;
        else          rst_q <= 1'b1;
    end
    assign rst_n = rst_q;

    ines_load_fifo #(.W(8)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (fifo_clr),
        .push     (push),
        .push_dat (in_data),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    assign fifo_empty = (count == 3'd0);
    assign push       = in_valid && in_ready && busy;
    assign prg_last   = {prg_banks, 14'd0} - 22'd1;
    assign chr_last   = {1'b0, chr_banks, 13'd0} - 22'd1;

    // Expected "NES\x1A" signature byte for the current header position.
    always_comb begin
        magic_byte = 8'h00;
        case (hdr_idx[1:0])
            2'd0: magic_byte = 8'h4E;
            2'd1: magic_byte = 8'h45;
            2'd2: magic_byte = 8'h53;
            2'd3: magic_byte = 8'h1A;
            default: magic_byte = 8'h00;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state, handshake and memory-port decode.
    always_comb begin
        state_nxt    = state;
        fifo_clr     = 1'b0;
        pop          = 1'b0;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        busy         = 1'b0;
        done         = (state == S_DONE);
        error        = (state == S_ERROR);
        hdr_take     = 1'b0;
        off_inc      = 1'b0;
        off_clr      = 1'b0;
        err_set      = 1'b0;
        err_code_nxt = 2'd0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                // Idle holds the source off; terminal states sink and drop bytes.
                in_ready = (state != S_IDLE);
                if (start) begin
                    fifo_clr  = 1'b1;
                    state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                busy     = 1'b1;
                in_ready = (count < 3'd4);
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    hdr_take = 1'b1;
                    if (hdr_idx < 4'd4 && head_dat != magic_byte) begin
                        state_nxt    = S_ERROR;
                        err_set      = 1'b1;
                        err_code_nxt = 2'd1;
                    end else if (hdr_idx == 4'd15) begin
                        if (prg_banks == 8'd0 || int'(prg_banks) > MAX_PRG_BANKS ||
                            int'(chr_banks) > MAX_CHR_BANKS) begin
                            state_nxt    = S_ERROR;
                            err_set      = 1'b1;
                            err_code_nxt = 2'd2;
                        end else begin
                            state_nxt = trainer_flag ? S_TRAINER : S_PRG;
                        end
                    end
                end
            end
            S_TRAINER: begin
                busy     = 1'b1;
                in_ready = (count < 3'd4);
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (offset == 22'd511) begin
                        off_clr   = 1'b1;
                        state_nxt = S_PRG;
                    end else begin
                        off_inc = 1'b1;
                    end
                end
            end
            S_PRG, S_CHR: begin
                busy      = 1'b1;
                in_ready  = (count < 3'd4);
                mem_we    = !fifo_empty;
                mem_addr  = ((state == S_PRG) ? PRG_BASE : CHR_BASE) + offset;
                mem_wdata = fifo_empty ? 8'h00 : head_dat;
                if (!fifo_empty && mem_ready) begin
                    pop = 1'b1;
                    if (state == S_PRG && offset == prg_last) begin
                        off_clr   = 1'b1;
                        state_nxt = (chr_banks != 8'd0) ? S_CHR : S_DONE;
                    end else if (state == S_CHR && offset == chr_last) begin
                        off_clr   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        off_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
`ifdef LOADER_TIMEOUT_EN
        // A source silent for too long aborts the load; suppress any write that cycle.
        if (busy && idle_cnt == 20'hFFFFF) begin
            state_nxt    = S_ERROR;
            err_set      = 1'b1;
            err_code_nxt = 2'd3;
            pop          = 1'b0;
            mem_we       = 1'b0;
            mem_addr     = '0;
            mem_wdata    = '0;
            hdr_take     = 1'b0;
            off_inc      = 1'b0;
            off_clr      = 1'b0;
        end
`endif
    end

    // Byte offset (trainer skip count, then PRG/CHR write address) and header position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset  <= '0;
            hdr_idx <= '0;
        end else if (fifo_clr) begin
            offset  <= '0;
            hdr_idx <= '0;
        end else begin
            if (off_clr)      offset <= '0;
            else if (off_inc) offset <= offset + 22'd1;
            if (hdr_take)     hdr_idx <= hdr_idx + 4'd1;
        end
    end

    // Header fields and error code; held until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prg_banks    <= '0;
            chr_banks    <= '0;
            mapper       <= '0;
            mirror       <= 1'b0;
            trainer_flag <= 1'b0;
            err_code     <= '0;
        end else if (fifo_clr) begin
            prg_banks    <= '0;
            chr_banks    <= '0;
            mapper       <= '0;
            mirror       <= 1'b0;
            trainer_flag <= 1'b0;
            err_code     <= '0;
        end else begin
            if (err_set) err_code <= err_code_nxt;
            if (hdr_take) begin
                case (hdr_idx)
                    4'd4: prg_banks <= head_dat;
                    4'd5: chr_banks <= head_dat;
                    4'd6: begin
                        mirror       <= head_dat[0];
                        trainer_flag <= head_dat[2];
                        mapper[3:0]  <= head_dat[7:4];
                    end
                    4'd7: mapper[7:4] <= head_dat[7:4];
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Busy cycles since the last accepted input byte, saturating at the abort threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     idle_cnt <= '0;
        else if (!busy || push)         idle_cnt <= '0;
        else if (idle_cnt != 20'hFFFFF) idle_cnt <= idle_cnt + 20'd1;
    end
`endif
endmodule

// File: tb/tb_ines_load_ctrl.sv
module tb_ines_load_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic        busy, done, error, mirror;
    logic [1:0]  err_code;
    logic [7:0]  mapper, prg_banks, chr_banks;

    int          errors = 0;
    int          checks = 0;
    logic [29:0] exp_q[$];
    int          wr_cnt = 0;
    int          acc_cnt = 0;
    bit          occ_chk_en = 1'b0;
    int          rdy_low_seen = 0;
    int          mr_mode = 0;
    int          mr_cyc = 0;
    bit          stall_prev = 1'b0;
    logic [21:0] stall_addr;
    logic [7:0]  stall_dat;
    logic [29:0] first_wr;
    int          occ;
    logic [29:0] e;

    ines_load_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .mapper(mapper), .prg_banks(prg_banks), .chr_banks(chr_banks), .mirror(mirror)
    );

    always #5 clk = ~clk;

    // mem_ready pattern: always ready, or ready one cycle in three.
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            mr_cyc++;
            mem_ready = (mr_mode == 0) ? 1'b1 : (mr_cyc % 3 == 0);
        end
    end

    // Monitor: scoreboard pops on every accepted write, stall stability, FIFO occupancy model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (!(mem_we === 1'b1 && mem_addr === stall_addr && mem_wdata === stall_dat)) begin
                        errors++;
                        $display("FAIL stall_hold we=%b addr=%h dat=%h required we=1 addr=%h dat=%h",
                                 mem_we, mem_addr, mem_wdata, stall_addr, stall_dat);
                    end
                end
                stall_prev = mem_we && !mem_ready;
                stall_addr = mem_addr;
                stall_dat  = mem_wdata;
                if (occ_chk_en && busy && wr_cnt > 0) begin
                    occ = acc_cnt - 16 - wr_cnt;
                    checks++;
                    if (in_ready !== (occ < 4)) begin
                        errors++;
                        $display("FAIL in_ready_occ in_ready=%b required=%b (model occupancy %0d)",
                                 in_ready, (occ < 4), occ);
                    end
                    if (!in_ready) rdy_low_seen++;
                end
                if (mem_we && mem_ready) begin
                    checks++;
                    if (wr_cnt == 0) first_wr = {mem_addr, mem_wdata};
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write addr=%h dat=%h required no write", mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if ({mem_addr, mem_wdata} !== e) begin
                            errors++;
                            $display("FAIL write addr=%h dat=%h required addr=%h dat=%h",
                                     mem_addr, mem_wdata, e[29:8], e[7:0]);
                        end
                    end
                    wr_cnt++;
                end
                if (in_valid && in_ready && busy) acc_cnt++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 2000) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                               input logic [7:0] b6, input logic [7:0] b7);
        logic [7:0] h [16];
        for (int i = 0; i < 16; i++) h[i] = 8'h00;
        h[0] = 8'h4E; h[1] = 8'h45; h[2] = 8'h53; h[3] = b3;
        h[4] = b4;    h[5] = b5;    h[6] = b6;    h[7] = b7;
        for (int i = 0; i < 16; i++) send_byte(h[i]);
    endtask

    task automatic send_data(input int n, input logic [21:0] base, input bit expect_wr);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom_range(0, 254));
            if (expect_wr) exp_q.push_back({base + 22'(i), d});
            send_byte(d);
        end
    endtask

    task automatic start_load();
        exp_q.delete();
        wr_cnt  = 0;
        acc_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_writes(input int total, input int bound);
        int t;
        t = 0;
        while (wr_cnt < total && t < bound) begin
            @(posedge clk); #2;
            t++;
        end
        checks++;
        if (wr_cnt != total) begin
            errors++;
            $display("FAIL write_count got=%0d required=%0d", wr_cnt, total);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #2 reset_n = 1'b0;
        #10;
        checks++;
        if ({busy, done, error, mem_we, in_ready, mirror} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b required=000000", {busy, done, error, mem_we, in_ready, mirror});
        end
        checks++;
        if ({mem_addr, mem_wdata, err_code} !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem got addr=%h dat=%h err=%0d required 0", mem_addr, mem_wdata, err_code);
        end
        checks++;
        if ({mapper, prg_banks, chr_banks} !== 24'h0) begin
            errors++;
            $display("FAIL reset_fields got=%h required=000000", {mapper, prg_banks, chr_banks});
        end
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b1; in_data = 8'h4E;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_in_ready in_ready=%b busy=%b required 0 0", in_ready, busy);
            end
        end
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic test_main_load();
        occ_chk_en = 1'b1;
        mr_mode    = 0;
        start_load();
        send_header(8'h1A, 8'h02, 8'h01, 8'h01, 8'h00);
        send_data(200, 22'd0, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL main_busy got=%b required=1", busy);
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        send_data(32768 - 200, 22'd200, 1'b1);
        send_data(8192, 22'h080000, 1'b1);
        wait_writes(40960, 200);
        checks++;
        if ({done, error, busy, mirror} !== 4'b1001) begin
            errors++;
            $display("FAIL main_status done/error/busy/mirror=%b required=1001", {done, error, busy, mirror});
        end
        checks++;
        if ({mapper, prg_banks, chr_banks, err_code} !== {8'h00, 8'h02, 8'h01, 2'd0}) begin
            errors++;
            $display("FAIL main_fields mapper=%h prg=%h chr=%h err=%0d required 00 02 01 0",
                     mapper, prg_banks, chr_banks, err_code);
        end
        send_data(5, 22'd0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (wr_cnt != 40960 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_discard writes=%0d done=%b required 40960 1", wr_cnt, done);
        end
    endtask

    task automatic test_bad_magic();
        start_load();
        send_byte(8'h4E); send_byte(8'h45); send_byte(8'h53);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL magic_early error=%b busy=%b required 0 1", error, busy);
        end
        send_byte(8'h1B);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({error, err_code, busy, in_ready} !== 5'b1_01_0_1) begin
            errors++;
            $display("FAIL magic_err error=%b code=%0d busy=%b in_ready=%b required 1 1 0 1",
                     error, err_code, busy, in_ready);
        end
        for (int i = 0; i < 28; i++) send_byte(8'($urandom_range(0, 255)));
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt != 0 || err_code !== 2'd1) begin
            errors++;
            $display("FAIL magic_nowrite writes=%0d code=%0d required 0 1", wr_cnt, err_code);
        end
    endtask

    task automatic test_bad_counts();
        logic [7:0] b4s [3];
        logic [7:0] b5s [3];
        logic [7:0] b6s [3];
        logic [7:0] b7s [3];
        b4s = '{8'h00, 8'h21, 8'h20};
        b5s = '{8'h01, 8'h00, 8'h21};
        b6s = '{8'h00, 8'h51, 8'h00};
        b7s = '{8'h00, 8'hA0, 8'h00};
        for (int k = 0; k < 3; k++) begin
            start_load();
            checks++;
            if (error !== 1'b0 || err_code !== 2'd0) begin
                errors++;
                $display("FAIL start_clears case=%0d error=%b code=%0d required 0 0", k, error, err_code);
            end
            send_header(8'h1A, b4s[k], b5s[k], b6s[k], b7s[k]);
            send_data(8, 22'd0, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if ({error, err_code} !== 3'b1_10 || wr_cnt != 0 || prg_banks !== b4s[k]) begin
                errors++;
                $display("FAIL count_err case=%0d error=%b code=%0d writes=%0d prg=%h required 1 2 0 %h",
                         k, error, err_code, wr_cnt, prg_banks, b4s[k]);
            end
        end
        checks++;
        if (mapper !== 8'h00 || chr_banks !== 8'h21) begin
            errors++;
            $display("FAIL count_fields mapper=%h chr=%h required 00 21", mapper, chr_banks);
        end
    endtask

    task automatic test_mapper_fields();
        start_load();
        send_header(8'h1A, 8'h21, 8'h00, 8'h51, 8'hA0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mapper, mirror, err_code} !== {8'hA5, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL mapper_fields mapper=%h mirror=%b code=%0d required A5 1 2", mapper, mirror, err_code);
        end
    endtask

    task automatic test_trainer();
        logic [7:0] d0;
        occ_chk_en = 1'b0;
        start_load();
        send_header(8'h1A, 8'h01, 8'h00, 8'h04, 8'h00);
        for (int i = 0; i < 512; i++) send_byte(8'hFF);
        d0 = 8'($urandom_range(0, 254));
        exp_q.push_back({22'h0, d0});
        send_byte(d0);
        send_data(16383, 22'd1, 1'b1);
        wait_writes(16384, 200);
        checks++;
        if (first_wr !== {22'h0, d0}) begin
            errors++;
            $display("FAIL trainer_first got=%h required=%h", first_wr, {22'h0, d0});
        end
        checks++;
        if ({done, error, chr_banks, mapper, mirror} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL trainer_done done=%b error=%b chr=%h mapper=%h mirror=%b required 1 0 00 00 0",
                     done, error, chr_banks, mapper, mirror);
        end
    endtask

    task automatic test_stall_and_reset();
        occ_chk_en   = 1'b1;
        rdy_low_seen = 0;
        mr_mode      = 1;
        start_load();
        send_header(8'h1A, 8'h20, 8'h20, 8'h00, 8'h00);
        send_data(300, 22'd0, 1'b1);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1 || wr_cnt < 296) begin
            errors++;
            $display("FAIL stall_progress error=%b busy=%b writes=%0d required 0 1 >=296", error, busy, wr_cnt);
        end
        checks++;
        if (rdy_low_seen == 0) begin
            errors++;
            $display("FAIL stall_backpressure in_ready low cycles=%0d required >0", rdy_low_seen);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, busy, in_ready, done, error} !== 5'b0 || mem_addr !== 22'h0 ||
            {prg_banks, chr_banks, mapper} !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid we=%b busy=%b rdy=%b addr=%h prg=%h chr=%h required all 0",
                     mem_we, busy, in_ready, mem_addr, prg_banks, chr_banks);
        end
        exp_q.delete();
        mr_mode = 0;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b in_ready=%b we=%b required 0 0 0", busy, in_ready, mem_we);
        end
        start_load();
        send_header(8'h1A, 8'h01, 8'h00, 8'h00, 8'h00);
        send_data(16384, 22'd0, 1'b1);
        wait_writes(16384, 200);
        checks++;
        if ({done, error, prg_banks} !== {1'b1, 1'b0, 8'h01} || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reload done=%b error=%b prg=%h pending=%0d required 1 0 01 0",
                     done, error, prg_banks, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_main_load();
        test_bad_magic();
        test_bad_counts();
        test_mapper_fields();
        test_trainer();
        test_stall_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #990000;
        $display("FAIL watchdog time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
